operand2_issue_ctrl: RTL and testbench
======================================

# operand2_issue_ctrl

Sequences the SPARC operand2 source path between decode and execute. It classifies each accepted instruction into a 4-bit operand2 select code (Is), an immediate field and a register value. It holds each result in a 2-entry skid buffer and issues it to the EX stage, which owns the operand2 mux, under a valid/ready handshake. Register-sourced operands whose rs2 producer is still in flight wait in the buffer until a forwarded value arrives.

## Interface
Parameters:
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  drop all buffered entries; the same-cycle input is not accepted.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  block can accept.
- id_instr  in  32  instruction word.
- id_rs2_val  in  32  register-file value for rs2.
- rs2_pending  in  1  the rs2 producer has not yet written back.
- fwd_valid  in  1  the forwarded rs2 result is valid this cycle.
- fwd_data  in  32  forwarded rs2 value.
- ex_valid  out  1  head entry is issuable.
- ex_ready  in  1  EX consumes the head entry.
- ex_is  out  4  operand2 select code.
- ex_imm  out  22  immediate field, always id_instr[21:0].
- ex_r  out  32  register operand.
- ex_n2_used  out  1  operand2 is meaningful for this instruction.
- stall_cnt  out  CNT_W  saturating count of head-wait cycles.

## Operation
Decode, op = instr[31:30], i = instr[13]:
- op=00, op2=100 (SETHI): Is=0000, n2_used=1.
- op=00, other op2 (branches): Is=0100, n2_used=1.
- op=01 (CALL): Is=1000, n2_used=0, never waits.
- op=1x, op3 in {100101, 100110, 100111} (shifts): i=0 gives Is=1010; i=1 gives Is=1011.
- op=1x, otherwise: i=0 gives Is=1000; i=1 gives Is=1001.

Register-sourced classes are Is 1000 and 1010, except CALL. These are the only classes that capture R or can wait.

Accept and wait rules:
- Accept condition: id_valid && id_ready && !flush.
- On accept, R = id_rs2_val. If the entry is register-sourced and rs2_pending=1, it is stored with wait=1.
- If fwd_valid=1 in the same cycle as that accept, R = fwd_data and wait=0.
- fwd_valid with a waiting entry present: that entry's R is loaded with fwd_data and wait is cleared.

Buffer control:
- id_ready = rst_n && (count<2) && !any_wait. It depends only on registered state, with no path from ex_ready.
- ex_valid = (count>0) && !head.wait.
- Pop when ex_valid && ex_ready. Entries issue in FIFO order.
- Simultaneous push and pop with count=1 leaves count=1. With count=2, a pop moves the skid entry to head.
- Because id_ready=0 while any entry waits, at most one entry waits at a time, and it is the most recently accepted.

Flush and reset:
- flush: count goes to 0 and wait goes to 0. stall_cnt is unchanged.
- Priority: reset over flush over accept/pop/fwd.

stall_cnt:
- Increments every cycle that count>0 and head.wait=1.
- Saturates at 2^CNT_W-1.
- Cleared only by reset.

## Timing
- Reset values: count=0, all waits 0, id_ready=0 while rst_n=0 and 1 on the first cycle after. ex_valid=0, ex_is=0, ex_imm=0, ex_r=0, ex_n2_used=0, stall_cnt=0.
- Latency: an instruction accepted in cycle N into an empty buffer drives ex_* with ex_valid=1 in cycle N+1.
- Throughput: one instruction per cycle while ex_ready=1.
- Backpressure: with ex_ready=0, two entries are absorbed, then id_ready drops in the following cycle.
- Wait release: fwd_valid in cycle M raises ex_valid in M+1 with ex_r=fwd_data.
- Reset mid-operation: all entries are lost with no issue. The next cycle matches the reset values.
- ex_* outputs hold stable while ex_valid=1 && ex_ready=0.

## Structure
- Shared package proj_operand_pkg holds the Is constants:
  - IS_IMM22_HI=0000
  - IS_DISP22_SX=0100
  - IS_REG=1000
  - IS_SIMM13_SX=1001
  - IS_SHCNT_REG=1010
  - IS_SHCNT_IMM=1011
- The same package holds the shift op3 constants and the entry struct {is, imm, r, n2_used, wait}.
- Sub-module operand2_decode is purely combinational: instr in; is, n2_used and reg_sourced out.
- Top level contains the two entry registers, the count, the wait/forward logic and stall_cnt.

## Test plan
- Reset then SETHI 0x03000001 with ex_ready=1: N+1 gives ex_valid=1, ex_is=0000, ex_imm=0x000001, ex_n2_used=1.
- ADD 0x82003FFF, then SLL 0x83282005, back-to-back: these issue in order with ex_is=1001 (ex_imm[12:0]=0x1FFF), then ex_is=1011 (ex_imm[4:0]=5).
- ADD 0x82000002 with rs2_pending=1 and id_rs2_val=0x11:
  - ex_valid stays 0 and stall_cnt counts each cycle.
  - fwd_valid with fwd_data=0xDEADBEEF in cycle M gives ex_valid=1 and ex_r=0xDEADBEEF in M+1.
  - id_ready=0 throughout the wait.
- ex_ready=0 with three valid instructions offered: two accepted, then id_ready=0. Releasing ex_ready drains them in order, one per cycle.
- flush with count=2 and id_valid=1: the next cycle has ex_valid=0 and count=0, and the flushed-cycle instruction never issues.
- Force stall_cnt to saturate with CNT_W=4: it holds at 15.

Source files
------------

// File: rtl/proj_operand_pkg.sv
// Shared operand2 definitions: select codes, opcode fields
// and the buffered issue entry.
package proj_operand_pkg;

    localparam logic [3:0] IS_IMM22_HI  = 4'b0000;
    localparam logic [3:0] IS_DISP22_SX = 4'b0100;
    localparam logic [3:0] IS_REG       = 4'b1000;
    localparam logic [3:0] IS_SIMM13_SX = 4'b1001;
    localparam logic [3:0] IS_SHCNT_REG = 4'b1010;
    localparam logic [3:0] IS_SHCNT_IMM = 4'b1011;

    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;

    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_SLL = 6'b100101;
    localparam logic [5:0] OP3_SRL = 6'b100110;
    localparam logic [5:0] OP3_SRA = 6'b100111;

    // wt: rs2 producer still in flight, entry not issuable yet
    typedef struct packed {
        logic [3:0]  is;
        logic [21:0] imm;
        logic [31:0] r;
        logic        n2_used;
        logic        wt;
    } entry_t;

endpackage

// File: rtl/operand2_decode.sv
// Combinational operand2 classifier: maps an instruction word
// to its select code, use flag and register-sourced flag.
module operand2_decode
    import proj_operand_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  is,
    output logic        n2_used,
    output logic        reg_sourced
);

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       imm_i;
    logic       shift;
    logic       unused_ok;

    assign op    = instr[31:30];
    assign op2   = instr[24:22];
    assign op3   = instr[24:19];
    assign imm_i = instr[13];
    assign shift = (op3 == OP3_SLL) || (op3 == OP3_SRL)
                || (op3 == OP3_SRA);

    // rd, rs1 and the low operand bits do not affect the class
    assign unused_ok = ^{instr[29:25], instr[18:14], instr[12:0]};

    // One-hot class select; CALL is never register-sourced
    always_comb begin
        is          = IS_IMM22_HI;
        n2_used     = 1'b1;
        reg_sourced = 1'b0;
        unique case (1'b1)
            (op == OP_FMT2) && (op2 == OP2_SETHI): begin
                is = IS_IMM22_HI;
            end
            (op == OP_FMT2) && (op2 != OP2_SETHI): begin
                is = IS_DISP22_SX;
            end
            (op == OP_CALL): begin
                is      = IS_REG;
                n2_used = 1'b0;
            end
            op[1] && shift: begin
                is          = imm_i ? IS_SHCNT_IMM : IS_SHCNT_REG;
                reg_sourced = !imm_i;
            end
            op[1] && !shift: begin
                is          = imm_i ? IS_SIMM13_SX : IS_REG;
                reg_sourced = !imm_i;
            end
            default: begin
                is = IS_IMM22_HI;
            end
        endcase
    end

endmodule

// File: rtl/operand2_issue_ctrl.sv
// Operand2 issue control: 2-entry skid buffer between decode
// and EX with rs2 wait/forward handling and a stall counter.
module operand2_issue_ctrl
    import proj_operand_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_rs2_val,
    input  logic             rs2_pending,
    input  logic             fwd_valid,
    input  logic [31:0]      fwd_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [3:0]       ex_is,
    output logic [21:0]      ex_imm,
    output logic [31:0]      ex_r,
    output logic             ex_n2_used,
    output logic [CNT_W-1:0] stall_cnt
);

    entry_t     ent0;
    entry_t     ent1;
    entry_t     n0;
    entry_t     n1;
    entry_t     new_ent;
    logic [1:0] count;
    logic [1:0] n_count;

    logic [3:0] dec_is;
    logic       dec_n2;
    logic       dec_reg;

    logic       any_wait;
    logic       head_wait;
    logic       acc;
    logic       pop;

    operand2_decode u_dec (
        .instr       (id_instr),
        .is          (dec_is),
        .n2_used     (dec_n2),
        .reg_sourced (dec_reg)
    );

    assign head_wait = (count != 2'd0) && ent0.wt;
    assign any_wait  = head_wait || ((count == 2'd2) && ent1.wt);

    // Registered-state only: no combinational path from ex_ready
    assign id_ready = rst_n && (count != 2'd2) && !any_wait;
    assign ex_valid = (count != 2'd0) && !ent0.wt;

    assign acc = id_valid && id_ready && !flush;
    assign pop = ex_valid && ex_ready;

    assign ex_is      = ent0.is;
    assign ex_imm     = ent0.imm;
    assign ex_r       = ent0.r;
    assign ex_n2_used = ent0.n2_used;

    // Build the incoming entry; same-cycle forward beats the wait
    always_comb begin
        new_ent         = '0;
        new_ent.is      = dec_is;
        new_ent.imm     = id_instr[21:0];
        new_ent.n2_used = dec_n2;
        if (dec_reg) begin
            if (rs2_pending && fwd_valid) begin
                new_ent.r = fwd_data;
            end else begin
                new_ent.r  = id_rs2_val;
                new_ent.wt = rs2_pending;
            end
        end
    end

    // Next buffer state: forward, then pop, then push, flush last
    always_comb begin
        n0      = ent0;
        n1      = ent1;
        n_count = count;
        if (fwd_valid) begin
            if (head_wait) begin
                n0.r  = fwd_data;
                n0.wt = 1'b0;
            end
            if ((count == 2'd2) && ent1.wt) begin
                n1.r  = fwd_data;
                n1.wt = 1'b0;
            end
        end
        if (pop) begin
            n0      = n1;
            n_count = count - 2'd1;
        end
        if (acc) begin
            if (n_count == 2'd0) begin
                n0 = new_ent;
            end else begin
                n1 = new_ent;
            end
            n_count = n_count + 2'd1;
        end
        if (flush) begin
            n_count = 2'd0;
            n0.wt   = 1'b0;
            n1.wt   = 1'b0;
        end
    end

    // Buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            ent0  <= n0;
            ent1  <= n1;
            count <= n_count;
        end
    end

    // Saturating count of cycles the head spends waiting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (head_wait && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand2_issue_ctrl.sv
// Directed self-checking bench for operand2_issue_ctrl,
// built with a 4-bit stall counter to reach saturation.
module tb_operand2_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_instr = 32'h0;
    logic [31:0] id_rs2_val = 32'h0;
    logic        rs2_pending = 1'b0;
    logic        fwd_valid = 1'b0;
    logic [31:0] fwd_data = 32'h0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [3:0]  ex_is;
    logic [21:0] ex_imm;
    logic [31:0] ex_r;
    logic        ex_n2_used;
    logic [3:0]  stall_cnt;

    int nchk = 0;
    int nfail = 0;

    localparam logic [31:0] SETHI = 32'h03000001;
    localparam logic [31:0] ADDI  = 32'h82003FFF;
    localparam logic [31:0] SLLI  = 32'h83282005;
    localparam logic [31:0] ADDR  = 32'h82000002;
    localparam logic [31:0] CALL  = 32'h40000010;
    localparam logic [31:0] BRA   = 32'h10800004;

    always #5 clk = ~clk;

    operand2_issue_ctrl #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_rs2_val  (id_rs2_val),
        .rs2_pending (rs2_pending),
        .fwd_valid   (fwd_valid),
        .fwd_data    (fwd_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_is       (ex_is),
        .ex_imm      (ex_imm),
        .ex_r        (ex_r),
        .ex_n2_used  (ex_n2_used),
        .stall_cnt   (stall_cnt)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nchk++; if (id_ready !== 1'b0) begin nfail++; $display("FAIL rst_id_ready got %0b exp 0", id_ready); end
        nchk++; if (ex_valid !== 1'b0) begin nfail++; $display("FAIL rst_ex_valid got %0b exp 0", ex_valid); end
        nchk++; if ({ex_is, ex_imm, ex_r, ex_n2_used} !== 59'h0) begin nfail++; $display("FAIL rst_ex_fields got %h/%h/%h/%0b exp 0", ex_is, ex_imm, ex_r, ex_n2_used); end
        nchk++; if (stall_cnt !== 4'd0) begin nfail++; $display("FAIL rst_stall got %0d exp 0", stall_cnt); end
        rst_n = 1'b1;
        #1;
        nchk++; if (id_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready got %0b exp 1", id_ready); end
    endtask

    task automatic test_sethi();
        @(negedge clk);
        ex_ready = 1'b1;
        id_valid = 1'b1;
        id_instr = SETHI;
        @(negedge clk);
        id_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1) begin nfail++; $display("FAIL sethi_valid got %0b exp 1", ex_valid); end
        nchk++; if (ex_is !== 4'b0000) begin nfail++; $display("FAIL sethi_is got %b exp 0000", ex_is); end
        nchk++; if (ex_imm !== 22'h000001) begin nfail++; $display("FAIL sethi_imm got %h exp 000001", ex_imm); end
        nchk++; if (ex_n2_used !== 1'b1) begin nfail++; $display("FAIL sethi_n2 got %0b exp 1", ex_n2_used); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0) begin nfail++; $display("FAIL sethi_drain got %0b exp 0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        id_valid = 1'b1;
        id_instr = ADDI;
        @(negedge clk);
        id_instr = SLLI;
        nchk++; if (ex_valid !== 1'b1 || ex_is !== 4'b1001) begin nfail++; $display("FAIL b2b_add_is got v=%0b is=%b exp v=1 is=1001", ex_valid, ex_is); end
        nchk++; if (ex_imm[12:0] !== 13'h1FFF) begin nfail++; $display("FAIL b2b_add_imm got %h exp 1fff", ex_imm[12:0]); end
        nchk++; if (id_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready got %0b exp 1", id_ready); end
        @(negedge clk);
        id_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_is !== 4'b1011) begin nfail++; $display("FAIL b2b_sll_is got v=%0b is=%b exp v=1 is=1011", ex_valid, ex_is); end
        nchk++; if (ex_imm[4:0] !== 5'd5) begin nfail++; $display("FAIL b2b_sll_imm got %0d exp 5", ex_imm[4:0]); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain got %0b exp 0", ex_valid); end
    endtask

    task automatic test_call_branch();
        id_valid = 1'b1;
        id_instr = CALL;
        rs2_pending = 1'b1;
        @(negedge clk);
        id_instr = BRA;
        rs2_pending = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_is !== 4'b1000 || ex_n2_used !== 1'b0) begin nfail++; $display("FAIL call got v=%0b is=%b n2=%0b exp v=1 is=1000 n2=0", ex_valid, ex_is, ex_n2_used); end
        @(negedge clk);
        id_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_is !== 4'b0100 || ex_n2_used !== 1'b1) begin nfail++; $display("FAIL branch got v=%0b is=%b n2=%0b exp v=1 is=0100 n2=1", ex_valid, ex_is, ex_n2_used); end
        @(negedge clk);
    endtask

    task automatic test_wait();
        id_valid = 1'b1;
        id_instr = ADDR;
        id_rs2_val = 32'h11;
        rs2_pending = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        rs2_pending = 1'b0;
        nchk++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin nfail++; $display("FAIL wait_hold got v=%0b rdy=%0b exp 0/0", ex_valid, id_ready); end
        nchk++; if (stall_cnt !== 4'd0) begin nfail++; $display("FAIL wait_stall0 got %0d exp 0", stall_cnt); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            nchk++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin nfail++; $display("FAIL wait_hold%0d got v=%0b rdy=%0b exp 0/0", k, ex_valid, id_ready); end
            nchk++; if (stall_cnt !== 4'(k)) begin nfail++; $display("FAIL wait_stall%0d got %0d exp %0d", k, stall_cnt, k); end
        end
        fwd_valid = 1'b1;
        fwd_data = 32'hDEADBEEF;
        @(negedge clk);
        fwd_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_r !== 32'hDEADBEEF) begin nfail++; $display("FAIL wait_release got v=%0b r=%h exp 1/deadbeef", ex_valid, ex_r); end
        nchk++; if (ex_is !== 4'b1000 || stall_cnt !== 4'd4) begin nfail++; $display("FAIL wait_is_stall got is=%b st=%0d exp 1000/4", ex_is, stall_cnt); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin nfail++; $display("FAIL wait_drain got v=%0b rdy=%0b exp 0/1", ex_valid, id_ready); end
    endtask

    task automatic test_fwd_same_cycle();
        id_valid = 1'b1;
        id_instr = ADDR;
        id_rs2_val = 32'h22;
        rs2_pending = 1'b1;
        fwd_valid = 1'b1;
        fwd_data = 32'h0000CAFE;
        @(negedge clk);
        id_valid = 1'b0;
        rs2_pending = 1'b0;
        fwd_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_r !== 32'h0000CAFE) begin nfail++; $display("FAIL fwd_same got v=%0b r=%h exp 1/0000cafe", ex_valid, ex_r); end
        nchk++; if (stall_cnt !== 4'd4) begin nfail++; $display("FAIL fwd_same_stall got %0d exp 4", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = ADDR;
        id_rs2_val = 32'hA1;
        @(negedge clk);
        id_rs2_val = 32'hA2;
        nchk++; if (id_ready !== 1'b1 || ex_r !== 32'hA1) begin nfail++; $display("FAIL bp_first got rdy=%0b r=%h exp 1/a1", id_ready, ex_r); end
        @(negedge clk);
        id_rs2_val = 32'hA3;
        nchk++; if (id_ready !== 1'b0) begin nfail++; $display("FAIL bp_full got rdy=%0b exp 0", id_ready); end
        @(negedge clk);
        nchk++; if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_r !== 32'hA1) begin nfail++; $display("FAIL bp_stable got rdy=%0b v=%0b r=%h exp 0/1/a1", id_ready, ex_valid, ex_r); end
        id_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b1 || ex_r !== 32'hA2) begin nfail++; $display("FAIL bp_second got v=%0b r=%h exp 1/a2", ex_valid, ex_r); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0) begin nfail++; $display("FAIL bp_drain got v=%0b exp 0", ex_valid); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = ADDR;
        id_rs2_val = 32'hB1;
        @(negedge clk);
        id_rs2_val = 32'hB2;
        @(negedge clk);
        id_rs2_val = 32'hB3;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin nfail++; $display("FAIL flush_full got v=%0b rdy=%0b exp 0/1", ex_valid, id_ready); end
        flush = 1'b1;
        id_valid = 1'b1;
        id_rs2_val = 32'hB4;
        ex_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b0) begin nfail++; $display("FAIL flush_noaccept got v=%0b exp 0", ex_valid); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd4) begin nfail++; $display("FAIL flush_after got v=%0b st=%0d exp 0/4", ex_valid, stall_cnt); end
    endtask

    task automatic test_saturate();
        id_valid = 1'b1;
        id_instr = ADDR;
        id_rs2_val = 32'h33;
        rs2_pending = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        rs2_pending = 1'b0;
        repeat (20) @(negedge clk);
        nchk++; if (stall_cnt !== 4'd15) begin nfail++; $display("FAIL sat_reach got %0d exp 15", stall_cnt); end
        repeat (3) @(negedge clk);
        nchk++; if (stall_cnt !== 4'd15 || ex_valid !== 1'b0) begin nfail++; $display("FAIL sat_hold got st=%0d v=%0b exp 15/0", stall_cnt, ex_valid); end
        fwd_valid = 1'b1;
        fwd_data = 32'h12345678;
        @(negedge clk);
        fwd_valid = 1'b0;
        nchk++; if (ex_valid !== 1'b1 || ex_r !== 32'h12345678) begin nfail++; $display("FAIL sat_release got v=%0b r=%h exp 1/12345678", ex_valid, ex_r); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = SLLI;
        @(negedge clk);
        id_instr = ADDI;
        @(negedge clk);
        id_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        nchk++; if (id_ready !== 1'b0) begin nfail++; $display("FAIL midrst_ready got %0b exp 0", id_ready); end
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin nfail++; $display("FAIL midrst_state got v=%0b st=%0d exp 0/0", ex_valid, stall_cnt); end
        nchk++; if ({ex_is, ex_imm, ex_r, ex_n2_used} !== 59'h0) begin nfail++; $display("FAIL midrst_fields got %h/%h/%h/%0b exp 0", ex_is, ex_imm, ex_r, ex_n2_used); end
        rst_n = 1'b1;
        ex_ready = 1'b1;
        @(negedge clk);
        nchk++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin nfail++; $display("FAIL midrst_after got v=%0b rdy=%0b exp 0/1", ex_valid, id_ready); end
    endtask

    initial begin
        test_reset();
        test_sethi();
        test_back_to_back();
        test_call_branch();
        test_wait();
        test_fwd_same_cycle();
        test_backpressure();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
